maze_solver: RTL and testbench

MAZE_SOLVER -- requirements
Module: maze_solver

---
 rtl/maze_pkg.sv | 30 +++
 rtl/maze_solver_if.sv | 12 +
 rtl/maze_wall_lookup.sv | 41 ++++
 rtl/maze_solver.sv | 140 ++++++++++++++
 tb/tb_maze_solver.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// Shared maze geometry, wall-vector widths and heading encoding for the
// solver and any maze generator built on the same grid.
package maze_pkg;
  localparam int unsigned COLS      = 15;
  localparam int unsigned ROWS      = 10;
  localparam int unsigned H_WALLS_W = (COLS + 1) * ROWS;
  localparam int unsigned V_WALLS_W = COLS * (ROWS + 1);
  localparam int unsigned COORD_W   = 4;
  localparam int unsigned STEPS_W   = 10;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Rotate a heading clockwise by rot quarter turns (3 = left, 1 = right).
  function automatic dir_e turn(dir_e d, logic [1:0] rot);
    logic [1:0] sum;
    sum = d + rot;
    return dir_e'(sum);
  endfunction
endpackage

// File: rtl/maze_solver_if.sv
// Position beat stream produced by the maze solver.
interface maze_solver_if;
  import maze_pkg::*;

  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;

  modport master (output out_valid, out_x, out_y, input out_ready);
  modport slave  (input out_valid, out_x, out_y, output out_ready);
endinterface

// File: rtl/maze_wall_lookup.sv
// Combinational open-side mask {W,S,E,N} of one cell from the wall snapshot.
// Coordinates outside the grid read as fully walled.
module maze_wall_lookup #(
  parameter int unsigned COLS = maze_pkg::COLS,
  parameter int unsigned ROWS = maze_pkg::ROWS
) (
  input  logic [(COLS+1)*ROWS-1:0]      h_walls,
  input  logic [COLS*(ROWS+1)-1:0]      v_walls,
  input  logic [maze_pkg::COORD_W-1:0]  x,
  input  logic [maze_pkg::COORD_W-1:0]  y,
  output logic [3:0]                    open_mask
);
  import maze_pkg::*;

  localparam int unsigned HW = (COLS + 1) * ROWS;
  localparam int unsigned VW = COLS * (ROWS + 1);

  int unsigned    xi;
  int unsigned    yi;
  logic [HW-1:0]  h_west;
  logic [HW-1:0]  h_east;
  logic [VW-1:0]  v_north;
  logic [VW-1:0]  v_south;

  // Shift-then-take-bit keeps the variable index width-agnostic.
  always_comb begin
    xi        = 32'(x);
    yi        = 32'(y);
    h_west    = h_walls >> (yi * (COLS + 1) + xi);
    h_east    = h_walls >> (yi * (COLS + 1) + xi + 1);
    v_north   = v_walls >> (yi * COLS + xi);
    v_south   = v_walls >> ((yi + 1) * COLS + xi);
    open_mask = '0;
    if (xi < COLS && yi < ROWS) begin
      open_mask[DIR_N] = ~v_north[0];
      open_mask[DIR_E] = ~h_east[0];
      open_mask[DIR_S] = ~v_south[0];
      open_mask[DIR_W] = ~h_west[0];
    end
  end
endmodule

// File: rtl/maze_solver.sv
// Left-hand wall follower: walks from (0,0) heading East toward the far
// corner, emitting one position beat per accepted handshake.
module maze_solver #(
  parameter int unsigned COLS      = maze_pkg::COLS,
  parameter int unsigned ROWS      = maze_pkg::ROWS,
  parameter int unsigned MAX_STEPS = 1023
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [(COLS+1)*ROWS-1:0]      h_walls,
  input  logic [COLS*(ROWS+1)-1:0]      v_walls,
  output logic                          busy,
  output logic                          done,
  output logic                          found,
  output logic [maze_pkg::STEPS_W-1:0]  steps,
  maze_solver_if.master                 out
);
  import maze_pkg::*;

  localparam int unsigned HW = (COLS + 1) * ROWS;
  localparam int unsigned VW = COLS * (ROWS + 1);
  localparam logic [COORD_W-1:0] GOAL_X     = COORD_W'(COLS - 1);
  localparam logic [COORD_W-1:0] GOAL_Y     = COORD_W'(ROWS - 1);
  localparam logic [STEPS_W-1:0] STEP_LIMIT = STEPS_W'(MAX_STEPS);

  state_e             state_q, state_d;
  logic [HW-1:0]      h_q, h_d;
  logic [VW-1:0]      v_q, v_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  dir_e               dir_q, dir_d;
  logic [STEPS_W-1:0] steps_q, steps_d;
  logic               found_q, found_d;

  logic [3:0] open_mask;
  dir_e       move_dir;
  dir_e       cand;
  logic       can_move;

  maze_wall_lookup #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_lookup (
    .h_walls   (h_q),
    .v_walls   (v_q),
    .x         (x_q),
    .y         (y_q),
    .open_mask (open_mask)
  );

  // Candidates in priority order left, straight, right, back: rot = 3,0,1,2.
  always_comb begin
    move_dir = dir_q;
    can_move = 1'b0;
    cand     = dir_q;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = turn(dir_q, 2'(k + 3));
      if (!can_move && open_mask[cand]) begin
        move_dir = cand;
        can_move = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    steps_d = steps_q;
    found_d = found_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          h_d     = h_walls;
          v_d     = v_walls;
          x_d     = '0;
          y_d     = '0;
          dir_d   = DIR_E;
          steps_d = '0;
          found_d = 1'b0;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out.out_ready) begin
          if (x_q == GOAL_X && y_q == GOAL_Y) begin
            found_d = 1'b1;
            state_d = ST_DONE;
          end else if (steps_q == STEP_LIMIT || !can_move) begin
            state_d = ST_DONE;
          end else begin
            dir_d   = move_dir;
            steps_d = steps_q + 1'b1;
            unique case (move_dir)
              DIR_N:   y_d = y_q - 1'b1;
              DIR_E:   x_d = x_q + 1'b1;
              DIR_S:   y_d = y_q + 1'b1;
              default: x_d = x_q - 1'b1;
            endcase
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      h_q     <= '1;
      v_q     <= '1;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= DIR_E;
      steps_q <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      steps_q <= steps_d;
      found_q <= found_d;
    end
  end

  assign busy          = (state_q == ST_EMIT);
  assign done          = (state_q == ST_DONE);
  assign found         = found_q;
  assign steps         = steps_q;
  assign out.out_valid = (state_q == ST_EMIT);
  assign out.out_x     = x_q;
  assign out.out_y     = y_q;
endmodule

// File: tb/tb_maze_solver.sv
// Randomized bench for maze_solver: a plain left-hand walker model predicts
// every beat and the final found/steps for a default and a MAX_STEPS=10 DUT.
`timescale 1ns/1ps
module tb_maze_solver;
  localparam int HW = 160;
  localparam int VW = 165;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [HW-1:0] h_walls = '1;
  logic [VW-1:0] v_walls = '1;
  logic          rdy = 1'b1;

  logic       busy0, done0, found0, busy1, done1, found1;
  logic [9:0] steps0, steps1;

  maze_solver_if bus0();
  maze_solver_if bus1();
  assign bus0.out_ready = rdy;
  assign bus1.out_ready = rdy;

  maze_solver dut (
    .clk(clk), .rst(rst), .start(start), .h_walls(h_walls), .v_walls(v_walls),
    .busy(busy0), .done(done0), .found(found0), .steps(steps0), .out(bus0)
  );

  maze_solver #(.MAX_STEPS(10)) dut_lim (
    .clk(clk), .rst(rst), .start(start), .h_walls(h_walls), .v_walls(v_walls),
    .busy(busy1), .done(done1), .found(found1), .steps(steps1), .out(bus1)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  bit         chk_en = 1'b0;
  logic [7:0] exp0_q[$];
  logic [7:0] exp1_q[$];
  int         exp_steps[2];
  bit         exp_found[2];

  function automatic void chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic bit wall_at(logic [HW-1:0] h, logic [VW-1:0] v, int x, int y, int d);
    logic [HW-1:0] hs;
    logic [VW-1:0] vs;
    case (d)
      0:       begin vs = v >> (y * 15 + x);       return vs[0]; end
      1:       begin hs = h >> (y * 16 + x + 1);   return hs[0]; end
      2:       begin vs = v >> ((y + 1) * 15 + x); return vs[0]; end
      default: begin hs = h >> (y * 16 + x);       return hs[0]; end
    endcase
  endfunction

  task automatic model_run(input logic [HW-1:0] h, input logic [VW-1:0] v,
                           input int max_steps, input int inst);
    int x, y, d, n, nd;
    bit fnd;
    int dx[4] = '{0, 1, 0, -1};
    int dy[4] = '{-1, 0, 1, 0};
    int rots[4] = '{3, 0, 1, 2};
    x = 0; y = 0; d = 1; n = 0; fnd = 1'b0;
    if (inst == 0) exp0_q.delete(); else exp1_q.delete();
    while (1) begin
      if (inst == 0) exp0_q.push_back({4'(x), 4'(y)});
      else           exp1_q.push_back({4'(x), 4'(y)});
      if (x == 14 && y == 9) begin fnd = 1'b1; break; end
      if (n == max_steps) break;
      nd = -1;
      for (int k = 0; k < 4; k++)
        if (nd < 0 && !wall_at(h, v, x, y, (d + rots[k]) % 4)) nd = (d + rots[k]) % 4;
      if (nd < 0) break;
      d = nd; x += dx[nd]; y += dy[nd]; n++;
      if (x < 0 || x > 14 || y < 0 || y > 9) break;
    end
    exp_steps[inst] = n;
    exp_found[inst] = fnd;
  endtask

  // Head of each queue must be on the bus whenever valid; popped on handshake.
  always @(negedge clk) begin
    if (chk_en) begin
      if (bus0.out_valid) begin
        if (exp0_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL beat0_extra: got (%0d,%0d) expected no beat", bus0.out_x, bus0.out_y);
        end else begin
          chk("beat0_xy", {bus0.out_x, bus0.out_y}, exp0_q[0]);
          if (rdy) void'(exp0_q.pop_front());
        end
      end
      if (bus1.out_valid) begin
        if (exp1_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL beat1_extra: got (%0d,%0d) expected no beat", bus1.out_x, bus1.out_y);
        end else begin
          chk("beat1_xy", {bus1.out_x, bus1.out_y}, exp1_q[0]);
          if (rdy) void'(exp1_q.pop_front());
        end
      end
    end
  end

  function automatic logic [HW-1:0] border_h();
    logic [HW-1:0] h = '0;
    for (int y = 0; y < 10; y++) h = h | (160'(1) << (y * 16)) | (160'(1) << (y * 16 + 15));
    return h;
  endfunction

  function automatic logic [VW-1:0] border_v();
    logic [VW-1:0] v = '0;
    for (int x = 0; x < 15; x++) v = v | (165'(1) << x) | (165'(1) << (150 + x));
    return v;
  endfunction

  task automatic check_idle(input string name);
    chk({name, "_busy0"}, busy0, 0);   chk({name, "_valid0"}, bus0.out_valid, 0);
    chk({name, "_done0"}, done0, 0);   chk({name, "_found0"}, found0, 0);
    chk({name, "_steps0"}, steps0, 0); chk({name, "_xy0"}, {bus0.out_x, bus0.out_y}, 0);
    chk({name, "_busy1"}, busy1, 0);   chk({name, "_valid1"}, bus1.out_valid, 0);
    chk({name, "_done1"}, done1, 0);
  endtask

  // rmode: 0 ready high, 1 random ready, 2 stall 5 cycles on (3,0), 3 stray start mid-run
  task automatic run_case(input string name, input logic [HW-1:0] h, input logic [VW-1:0] v,
                          input int rmode, input bit flip);
    int cyc = 0;
    int stall_cnt = 0;
    int held = 0;
    bit stalled = 1'b0;
    model_run(h, v, 1023, 0);
    model_run(h, v, 10, 1);
    @(posedge clk); #1;
    h_walls = h; v_walls = v; start = 1'b1; rdy = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (flip) begin h_walls = '1; v_walls = '1; end
    chk({name, "_busy_after_start"}, busy0, 1);
    chk({name, "_done_cleared"}, done0, 0);
    while (!(done0 && done1) && cyc < 4000) begin
      start = 1'b0;
      case (rmode)
        1: rdy = ($urandom_range(0, 3) != 0);
        2: begin
          if (!stalled && bus0.out_valid && bus0.out_x == 4'd3 && bus0.out_y == 4'd0) begin
            stalled = 1'b1; stall_cnt = 5;
          end
          if (stall_cnt > 0) begin
            rdy = 1'b0; stall_cnt--;
            if (bus0.out_valid && bus0.out_x == 4'd3 && bus0.out_y == 4'd0) held++;
          end else rdy = 1'b1;
        end
        3: begin
          rdy = 1'b1;
          if (cyc == 2) begin start = 1'b1; h_walls = '0; v_walls = '0; end
        end
        default: rdy = 1'b1;
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 4000) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, cyc);
    end
    @(negedge clk);
    if (rmode == 2) chk({name, "_stall_hold"}, held, 5);
    chk({name, "_done0"}, done0, 1);
    chk({name, "_found0"}, found0, exp_found[0]);
    chk({name, "_steps0"}, steps0, exp_steps[0]);
    chk({name, "_busy0"}, busy0, 0);
    chk({name, "_left0"}, exp0_q.size(), 0);
    chk({name, "_done1"}, done1, 1);
    chk({name, "_found1"}, found1, exp_found[1]);
    chk({name, "_steps1"}, steps1, exp_steps[1]);
    chk({name, "_left1"}, exp1_q.size(), 0);
  endtask

  task automatic reset_case(input logic [HW-1:0] h, input logic [VW-1:0] v);
    int cyc = 0;
    model_run(h, v, 1023, 0);
    model_run(h, v, 10, 1);
    @(posedge clk); #1;
    h_walls = h; v_walls = v; start = 1'b1; rdy = 1'b1; chk_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!(bus0.out_valid && bus0.out_x == 4'd5 && bus0.out_y == 4'd0) && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("rst_reached_beat5", {bus0.out_x, bus0.out_y}, {4'd5, 4'd0});
    chk_en = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle("midrun_rst");
    rst = 1'b1;
    exp0_q.delete(); exp1_q.delete();
  endtask

  logic [HW-1:0] open_h, rnd_h;
  logic [VW-1:0] open_v, rnd_v;

  initial begin
    open_h = border_h();
    open_v = border_v();

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_idle("reset");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("start_in_reset_dropped", busy0, 0);

    model_run(open_h, open_v, 1023, 0);
    chk("model_open_beats", exp0_q.size(), 24);
    chk("model_open_steps", exp_steps[0], 23);
    chk("model_open_found", exp_found[0], 1);
    chk("model_open_last", exp0_q[23], {4'd14, 4'd9});
    model_run(open_h, open_v, 10, 1);
    chk("model_lim_beats", exp1_q.size(), 11);
    chk("model_lim_steps", exp_steps[1], 10);
    chk("model_lim_last", exp1_q[10], {4'd10, 4'd0});
    model_run('1, '1, 1023, 0);
    chk("model_trap_beats", exp0_q.size(), 1);
    chk("model_trap_steps", exp_steps[0], 0);

    run_case("open", open_h, open_v, 0, 1'b0);
    run_case("stall", open_h, open_v, 2, 1'b0);
    run_case("trapped", '1, '1, 0, 1'b0);
    run_case("flip", open_h, open_v, 0, 1'b1);
    run_case("stray_start", open_h, open_v, 3, 1'b0);
    reset_case(open_h, open_v);
    run_case("rerun", open_h, open_v, 0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      int dens;
      dens  = $urandom_range(5, 40);
      rnd_h = '0;
      rnd_v = '0;
      for (int b = 0; b < HW; b++)
        if ($urandom_range(0, 99) < dens) rnd_h = rnd_h | (160'(1) << b);
      for (int b = 0; b < VW; b++)
        if ($urandom_range(0, 99) < dens) rnd_v = rnd_v | (165'(1) << b);
      run_case("random", rnd_h | open_h, rnd_v | open_v, 1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish before 900000ns");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end
endmodule
